// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream loader writing 9-bit X9 machine code into instruction memory
// Optional trailing checksum byte with CHK/ERR states: define LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [8:0]   wr_data,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err
);

  localparam int CW = D + 1;
  localparam logic [CW-1:0] MAX_CNT = {1'b1, {D{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    INS_LO,
    INS_HI,
`ifdef LOADER_CHECKSUM_EN
    CHK,
    ERR,
`endif
    DONE
  } state_t;

  state_t        state_q;
  logic [7:0]    cnt_lo_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] idx_q;
  logic [7:0]    hold_q;
  logic          in_ready_q;
  logic          wr_en_q;
  logic [D-1:0]  wr_addr_q;
  logic [8:0]    wr_data_q;
  logic          core_hold_q;
  logic          load_done_q;

  logic          fire;
  logic [15:0]   cnt_raw;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] idx_d;

  // Counts above 2^D clamp so a full-memory load is the largest possible.
  always_comb begin
    fire    = in_valid & in_ready_q;
    cnt_raw = {in_data, cnt_lo_q};
    cnt_d   = (32'(cnt_raw) > 32'(MAX_CNT)) ? MAX_CNT : cnt_raw[CW-1:0];
    idx_d   = idx_q + CW'(1);
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       load_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_q <= '0;
    end else if (start && !core_hold_q) begin
      xor_q <= '0;
    end else if (fire && (state_q inside {CNT_LO, CNT_HI, INS_LO, INS_HI})) begin
      xor_q <= xor_q ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_lo_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      core_hold_q <= 1'b0;
      load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_err_q  <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
`ifdef LOADER_CHECKSUM_EN
        IDLE, DONE, ERR: begin
`else
        IDLE, DONE: begin
`endif
          if (start) begin
            state_q     <= CNT_LO;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            load_err_q  <= 1'b0;
`endif
          end
        end
        CNT_LO: begin
          if (fire) begin
            cnt_lo_q <= in_data;
            state_q  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (fire) begin
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state_q     <= CHK;
`else
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              core_hold_q <= 1'b0;
              load_done_q <= 1'b1;
`endif
            end else begin
              state_q <= INS_LO;
            end
          end
        end
        INS_LO: begin
          if (fire) begin
            hold_q  <= in_data;
            state_q <= INS_HI;
          end
        end
        INS_HI: begin
          if (fire) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q[D-1:0];
            wr_data_q <= {in_data[0], hold_q};
            idx_q     <= idx_d;
            // The final write pulses in the same cycle the core is released.
            if (idx_d == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
              state_q     <= CHK;
`else
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              core_hold_q <= 1'b0;
              load_done_q <= 1'b1;
`endif
            end else begin
              state_q <= INS_LO;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (fire) begin
            in_ready_q  <= 1'b0;
            core_hold_q <= 1'b0;
            if (in_data == xor_q) begin
              state_q     <= DONE;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= ERR;
              load_err_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          core_hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = core_hold_q;
  assign load_done = load_done_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_err  = load_err_q;
`else
  assign load_err  = 1'b0;
`endif

endmodule

// File: doc/instr_loader.md
# instr_loader

Byte-stream program loader that writes 9-bit X9 machine code into instruction memory before the core runs. It is the writer for the instruction memory the core fetches from. The loader sits between an external host byte interface and the instruction-memory write port, and holds the core in reset until a load completes.

## Interface
- `D`, 12, instruction-memory address width; must match the core's program counter width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load. Sampled only in IDLE or DONE.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  D  instruction-memory write address.
- `wr_data`  out  9  machine code to write.
- `core_hold`  out  1  high while loading; keeps the core in reset.
- `load_done`  out  1  level; the last load finished successfully.
- `load_err`  out  1  level; the last load was aborted. Only used with the checksum feature; otherwise tied to 0.

## Operation
- States: IDLE, CNT_LO, CNT_HI, INS_LO, INS_HI, CHK (checksum build only), DONE, ERR.
- IDLE / DONE / ERR + `start`:
  - go to CNT_LO;
  - clear `load_done` and `load_err`;
  - reset the instruction index to 0.
- CNT_LO accepts count[7:0]. CNT_HI accepts count[15:8]. The effective count is count[D:0], with a maximum of 2^D.
  - If the effective count is 0, go to DONE (or to CHK in the checksum build).
  - If the count is greater than 2^D, saturate it to 2^D.
- INS_LO accepts mach_code[7:0] into a holding register.
- INS_HI accepts a byte whose bit 0 is mach_code[8]; bits [7:1] are ignored. On acceptance:
  - register a write of {bit0, holding} at address = index;
  - increment the index;
  - if the index reaches the count, go to DONE (or CHK); otherwise return to INS_LO.
- `in_ready` is 1 in CNT_LO, CNT_HI, INS_LO, INS_HI and CHK; it is 0 otherwise.
- `core_hold` is 1 in every state except IDLE, DONE and ERR.
- `start` is ignored while `core_hold` = 1.
- Bytes presented while `in_ready` = 0 are not consumed.
- Address arithmetic is modulo 2^D. A full 2^D load writes addresses 0 .. 2^D-1 exactly once.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_hold`=0, `load_done`=0, `load_err`=0, state IDLE.
- `start` at edge t puts the state in CNT_LO, so `in_ready`=1 from cycle t+1.
- Write latency: the INS_HI byte accepted at edge t produces `wr_en`=1 with `wr_addr` and `wr_data` stable during cycle t+1. `wr_en` is a one-cycle pulse.
- `load_done` and the deassertion of `core_hold` happen on the same edge as the final `wr_en` pulse. The last write completes on the edge that releases the core.
- Back-to-back bytes: one byte per cycle sustained, so a program of N instructions takes 2N+2 transfer cycles (+1 with checksum).
- `in_valid` may drop in any state; the state machine stalls with no side effects.
- Reset asserted mid-load returns all outputs to their reset values immediately. Instruction memory is left partially written, and `load_done` stays 0.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CHK state follows the last instruction and accepts one byte.
  - The running XOR covers every byte accepted in CNT_LO through INS_HI.
  - If the CHK byte equals the XOR, go to DONE with `load_done`=1.
  - Otherwise go to ERR with `load_err`=1 and `core_hold`=0. Memory contents are already written and are not rolled back.
- `LOADER_CHECKSUM_EN` undefined: no CHK/ERR states, no XOR register, and `load_err` is tied 0.

## Test plan
- Reset then idle: all outputs 0. `start` followed by bytes 0x02, 0x00, 0x5A, 0x01, 0x33, 0x00 produces:
  - `wr_en` pulses at (addr 0, data 0x15A) and (addr 1, data 0x033);
  - `load_done`=1 and `core_hold`=0 after the 6th byte.
- Count 0 (bytes 0x00, 0x00): no `wr_en`; `load_done`=1 two transfers after `start`.
- `in_valid` toggled 1,0,0,1 during INS_LO/INS_HI: identical write sequence to the unstalled case; `in_ready` never drops in load states.
- Reset pulled low after the first instruction of a 3-instruction load: outputs clear asynchronously. A subsequent full load writes addresses 0..2 correctly.
- `start` pulsed while `core_hold`=1: ignored, and the index is not reset.
- `LOADER_CHECKSUM_EN`, bytes 0x01, 0x00, 0x0F, 0x01:
  - CHK byte 0x0F (0x01^0x00^0x0F^0x01) gives `load_done`=1;
  - CHK byte 0x00 gives `load_err`=1 and `load_done`=0.
